// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 6;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the enable/flush controls returned to it.
interface pipe_hazard_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF
) ();

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic              mem_branch_taken;
  logic              dmem_busy;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic pc_sel_branch;

  // pipeline side: reports hazard sources, consumes the controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
           ex_mem_read, ex_reg_write, mem_branch_taken, dmem_busy,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
           ex_mem_read, ex_reg_write, mem_branch_taken, dmem_busy,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter; the async reset doubles as the clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the IF/ID, ID/EX, EX/MEM, MEM/WB register chain.
// state    | meaning
// RUN      | normal advance, load-use hazards checked each cycle
// LU_STALL | inserting the remaining load-use bubbles
// MEM_WAIT | whole chain frozen on dmem_busy; ret_q says where to resume
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::state_t, pipe_ctrl_pkg::RUN, pipe_ctrl_pkg::MEM_WAIT,
         pipe_ctrl_pkg::REG_AW_DEF, pipe_ctrl_pkg::ZERO_REG;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   hz,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count
);

  localparam logic [REG_AW-1:0] ZERO_RD  = REG_AW'(ZERO_REG);
  localparam logic [2:0]        LU_FIRST = 3'(LU_STALL - 1);

  state_t     st_q, st_d, ret_q, ret_d, eff_st;
  logic [2:0] cnt_q, cnt_d;
  logic       lu_hit;

  logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, pc_sel_c;

  assign lu_hit = hz.ex_mem_read && hz.ex_reg_write && (hz.ex_rd != ZERO_RD) &&
                  ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                   (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Leaving MEM_WAIT takes effect in the same cycle as the saved state.
  assign eff_st = (st_q == MEM_WAIT) ? ret_q : st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= RUN;
      ret_q <= RUN;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pc_en_c        = 1'b0;
    if_id_en_c     = 1'b0;
    id_ex_en_c     = 1'b0;
    ex_mem_en_c    = 1'b0;
    mem_wb_en_c    = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    pc_sel_c       = 1'b0;
    st_d           = RUN;
    ret_d          = ret_q;
    cnt_d          = cnt_q;

    if (!rst_n) begin
      ret_d = RUN;
      cnt_d = '0;
    end else if ((st_q != RUN) && (st_q != pipe_ctrl_pkg::LU_STALL) &&
                 (st_q != MEM_WAIT)) begin
      ret_d = RUN;
      cnt_d = '0;
    end else if (hz.dmem_busy) begin
      st_d  = MEM_WAIT;
      ret_d = (eff_st == pipe_ctrl_pkg::LU_STALL) ? pipe_ctrl_pkg::LU_STALL : RUN;
    end else if (hz.mem_branch_taken) begin
      pc_en_c        = 1'b1;
      if_id_en_c     = 1'b1;
      id_ex_en_c     = 1'b1;
      ex_mem_en_c    = 1'b1;
      mem_wb_en_c    = 1'b1;
      if_id_flush_c  = 1'b1;
      id_ex_flush_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
      pc_sel_c       = 1'b1;
      ret_d          = RUN;
      cnt_d          = '0;
    end else if ((eff_st == pipe_ctrl_pkg::LU_STALL) || lu_hit) begin
      id_ex_en_c    = 1'b1;
      ex_mem_en_c   = 1'b1;
      mem_wb_en_c   = 1'b1;
      id_ex_flush_c = 1'b1;
      ret_d         = RUN;
      cnt_d         = (eff_st == pipe_ctrl_pkg::LU_STALL) ? (cnt_q - 3'd1) : LU_FIRST;
      st_d          = (cnt_d != 3'd0) ? pipe_ctrl_pkg::LU_STALL : RUN;
    end else begin
      pc_en_c     = 1'b1;
      if_id_en_c  = 1'b1;
      id_ex_en_c  = 1'b1;
      ex_mem_en_c = 1'b1;
      mem_wb_en_c = 1'b1;
      ret_d       = RUN;
    end
  end

  assign hz.pc_en         = pc_en_c;
  assign hz.if_id_en      = if_id_en_c;
  assign hz.id_ex_en      = id_ex_en_c;
  assign hz.ex_mem_en     = ex_mem_en_c;
  assign hz.mem_wb_en     = mem_wb_en_c;
  assign hz.if_id_flush   = if_id_flush_c;
  assign hz.id_ex_flush   = id_ex_flush_c;
  assign hz.ex_mem_flush  = ex_mem_flush_c;
  assign hz.pc_sel_branch = pc_sel_c;
  assign state            = st_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en_c),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_sel_c),
    .count (flush_count)
  );

endmodule
